// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the EX-stage sequencer and the multiply/divide unit.
// Defining MULDIV_DIVZERO_FLAG_EN adds the divz_o divide-by-zero flag.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic [1:0]         op_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               annul_i;
    logic               busy_o;
    logic               ready_o;
    logic [2*WIDTH-1:0] result_o;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic               divz_o;
`endif

    modport master (
        output start_i, op_i, a_i, b_i, annul_i,
        input  busy_o, ready_o, result_o
`ifdef MULDIV_DIVZERO_FLAG_EN
        , input divz_o
`endif
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, annul_i,
        output busy_o, ready_o, result_o
`ifdef MULDIV_DIVZERO_FLAG_EN
        , output divz_o
`endif
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with pipeline stall, annul and registered {hi,lo} result.
// Optional divide-by-zero flag output is enabled by defining MULDIV_DIVZERO_FLAG_EN.
module muldiv_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL_ON = 3'd1;
    localparam logic [2:0] S_DIV_ON = 3'd2;
    localparam logic [2:0] S_DIV_Z  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   a_q, a_d;      // multiplicand, or dividend/quotient shift register
    logic [WIDTH-1:0]   b_q, b_d;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               start_go;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] a_ext, b_ext, product;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [WIDTH-1:0]   rem_n, quo_n, q_fix, r_fix;

    assign start_go  = bus.start_i && !bus.annul_i;
    assign op_signed = ~bus.op_i[0];
    assign a_mag     = (op_signed && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    assign b_mag     = (op_signed && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

    // Sign- or zero-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
    assign a_ext   = {{WIDTH{signed_q & a_q[WIDTH-1]}}, a_q};
    assign b_ext   = {{WIDTH{signed_q & b_q[WIDTH-1]}}, b_q};
    assign product = a_ext * b_ext;

    assign div_shift = {rem_q, a_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign rem_n     = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign quo_n     = {a_q[WIDTH-2:0], ~div_trial[WIDTH]};
    assign q_fix     = qneg_q ? -quo_n : quo_n;
    assign r_fix     = rneg_q ? -rem_n : rem_n;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave a value unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    cnt_d    = '0;
                    rem_d    = '0;
                    signed_d = op_signed;
                    if (!bus.op_i[1]) begin
                        a_d     = bus.a_i;
                        b_d     = bus.b_i;
                        state_d = S_MUL_ON;
                    end else if (bus.b_i == '0) begin
                        state_d = S_DIV_Z;
                    end else begin
                        a_d     = a_mag;
                        b_d     = b_mag;
                        qneg_d  = op_signed && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                        rneg_d  = op_signed && bus.a_i[WIDTH-1];
                        state_d = S_DIV_ON;
                    end
                end
            end

            S_MUL_ON: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    result_d = product;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DIV_ON: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    a_d   = quo_n;
                    rem_d = rem_n;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = {r_fix, q_fix};
                        state_d  = S_DONE;
                    end
                end
            end

            S_DIV_Z: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = '0;
                    state_d  = S_DONE;
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, so a reset mid-operation leaves no stale result behind.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o   = ((state_q == S_IDLE) && start_go)
                        || (((state_q == S_MUL_ON) || (state_q == S_DIV_ON) || (state_q == S_DIV_Z))
                            && !bus.annul_i);
    assign bus.ready_o  = (state_q == S_DONE) && !bus.annul_i;
    assign bus.result_o = result_q;

`ifdef MULDIV_DIVZERO_FLAG_EN
    logic divz_q, divz_d;

    // DIV_ZERO always proceeds to DONE unless annulled, so the flag marks exactly that DONE cycle.
    assign divz_d = (state_q == S_DIV_Z) && !bus.annul_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) divz_q <= 1'b0;
        else        divz_q <= divz_d;
    end

    assign bus.divz_o = divz_q && bus.ready_o;
`endif
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: vector table plus annul/reset/DONE sequences.
module tb_muldiv_ctrl;
    localparam int W       = 32;
    localparam int MUL_CYC = 1;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(.WIDTH(W), .MUL_CYCLES(MUL_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2*W-1:0] res;
        int            lat;
        string         name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_res, input int exp_lat, input string name);
        int lat;
        int busy_gaps;
        lat       = -1;
        busy_gaps = 0;
        next_cycle();
        bus.start_i = 1'b1;
        bus.annul_i = 1'b0;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        check({name, "_busy_c0"}, 64'(bus.busy_o), 64'd1);
        for (int n = 1; n <= 100; n++) begin
            next_cycle();
            bus.start_i = 1'b0;
            bus.op_i    = 2'($urandom);
            bus.a_i     = $urandom;
            bus.b_i     = $urandom;
            @(negedge clk);
            if (bus.ready_o) begin
                lat = n;
                break;
            end
            if (!bus.busy_o) busy_gaps++;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, bus.result_o, exp_res);
        check({name, "_busy_gaps"}, 64'(busy_gaps), 64'd0);
        check({name, "_busy_done"}, 64'(bus.busy_o), 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        check({name, "_divz"}, 64'(bus.divz_o), 64'(op[1] && (b == '0)));
`endif
        next_cycle();
        @(negedge clk);
        check({name, "_ready_pulse"}, 64'(bus.ready_o), 64'd0);
        check({name, "_result_hold"}, bus.result_o, exp_res);
    endtask

    initial begin
        int ready_seen;

        checks = 0;
        errors = 0;
        vecs[0]  = '{OP_DIVU,  32'd100,        32'd7,          {32'd2, 32'd14},               W + 1,       "divu_100_7"};
        vecs[1]  = '{OP_DIV,   32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},  W + 1,       "div_m7_2"};
        vecs[2]  = '{OP_DIV,   32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},         W + 1,       "div_ovf"};
        vecs[3]  = '{OP_MULT,  32'hFFFFFFFF,   32'd2,          64'hFFFFFFFF_FFFFFFFE,         MUL_CYC + 1, "mult_m1_2"};
        vecs[4]  = '{OP_MULTU, 32'hFFFFFFFF,   32'd2,          64'h00000001_FFFFFFFE,         MUL_CYC + 1, "multu_ff_2"};
        vecs[5]  = '{OP_DIV,   32'd5,          32'd0,          64'h0,                         2,           "div_by_zero"};
        vecs[6]  = '{OP_DIVU,  32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF},         W + 1,       "divu_ff_1"};
        vecs[7]  = '{OP_DIV,   32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},         W + 1,       "div_7_m2"};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3},         W + 1,       "div_m7_m2"};
        vecs[9]  = '{OP_MULT,  32'h80000000,   32'h80000000,   64'h40000000_00000000,         MUL_CYC + 1, "mult_min_min"};
        vecs[10] = '{OP_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001,         MUL_CYC + 1, "multu_ff_ff"};
        vecs[11] = '{OP_DIVU,  32'd5,          32'd10,         {32'd5, 32'd0},                W + 1,       "divu_5_10"};
        vecs[12] = '{OP_MULT,  32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1,         MUL_CYC + 1, "mult_m3_5"};
        vecs[13] = '{OP_DIVU,  32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0},         W + 1,       "divu_big"};

        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name);

        // start_i presented during DONE must be dropped
        next_cycle();
        bus.start_i = 1'b1; bus.op_i = OP_MULTU; bus.a_i = 32'd2; bus.b_i = 32'd3;
        next_cycle();
        bus.start_i = 1'b0;
        next_cycle();
        bus.start_i = 1'b1; bus.op_i = OP_MULTU; bus.a_i = 32'd5; bus.b_i = 32'd5;
        @(negedge clk);
        check("done_start_ready", 64'(bus.ready_o), 64'd1);
        check("done_start_busy", 64'(bus.busy_o), 64'd0);
        next_cycle();
        bus.start_i = 1'b0;
        ready_seen  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.ready_o || bus.busy_o) ready_seen++;
            next_cycle();
        end
        check("done_start_ignored", 64'(ready_seen), 64'd0);
        check("done_start_result", bus.result_o, 64'd6);

        // annul a DIVU at cycle 10, then a MULTU the following cycle
        bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.a_i = 32'd1000; bus.b_i = 32'd3;
        @(negedge clk);
        ready_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            bus.start_i = 1'b0;
            bus.annul_i = (c == 10);
            @(negedge clk);
            if (bus.ready_o) ready_seen++;
            if (c == 10) begin
                check("annul_busy_drop", 64'(bus.busy_o), 64'd0);
                check("annul_result_hold", bus.result_o, 64'd6);
            end
        end
        check("annul_no_ready", 64'(ready_seen), 64'd0);
        run_op(OP_MULTU, 32'd3, 32'd4, 64'd12, MUL_CYC + 1, "after_annul_multu");

        // start together with annul in IDLE is ignored
        next_cycle();
        bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.op_i = OP_MULT; bus.a_i = 32'd9; bus.b_i = 32'd9;
        @(negedge clk);
        check("idle_annul_busy", 64'(bus.busy_o), 64'd0);
        next_cycle();
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        ready_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.ready_o || bus.busy_o) ready_seen++;
            next_cycle();
        end
        check("idle_annul_ignored", 64'(ready_seen), 64'd0);
        check("idle_annul_result", bus.result_o, 64'd12);

        // annul in DONE: ready suppressed, result still updated
        bus.start_i = 1'b1; bus.op_i = OP_MULTU; bus.a_i = 32'd6; bus.b_i = 32'd7;
        next_cycle();
        bus.start_i = 1'b0;
        next_cycle();
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("done_annul_ready", 64'(bus.ready_o), 64'd0);
        check("done_annul_result", bus.result_o, 64'd42);
`ifdef MULDIV_DIVZERO_FLAG_EN
        check("done_annul_divz", 64'(bus.divz_o), 64'd0);
`endif
        next_cycle();
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("done_annul_after", 64'(bus.ready_o), 64'd0);

        // asynchronous reset at cycle 15 of a DIV
        next_cycle();
        bus.start_i = 1'b1; bus.op_i = OP_DIV; bus.a_i = 32'd1000; bus.b_i = 32'hFFFFFFFD;
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            bus.start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        check("rst_mid_ready", 64'(bus.ready_o), 64'd0);
        check("rst_mid_result", bus.result_o, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_busy", 64'(bus.busy_o), 64'd0);
        run_op(OP_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, W + 1, "after_rst_divu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide unit and sequencer for the EX stage. It serves MULT/MULTU/DIV/DIVU, which the single-cycle ALU does not execute.
- Upstream decode maps the EXE_*_OP code to a 2-bit op and pulses start. The block raises a pipeline stall while busy and returns the 64-bit {hi,lo} result to the HI/LO register write path with a one-cycle ready pulse.
- Supports annulment on exception/flush.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. The iteration counter is sized clog2(WIDTH)+1.
- MUL_CYCLES, 1, number of MUL_ON cycles (1..4); lets the multiplier be pipelined for timing.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- a_i  input  WIDTH  rs operand (dividend / multiplicand); sampled with start_i.
- b_i  input  WIDTH  rt operand (divisor / multiplier); sampled with start_i.
- annul_i  input  1  flush; abort current operation.
- busy_o  output  1  stall request to the pipeline.
- ready_o  output  1  one-cycle pulse: result_o valid, write HI/LO.
- result_o  output  2*WIDTH  {hi,lo}; MUL: product; DIV: {remainder, quotient}.

Behaviour:
- Reset: state=IDLE; result_o=0, ready_o=0, busy_o=0; all internal registers 0. Reset mid-operation aborts with no ready pulse.
- States: IDLE, MUL_ON, DIV_ON, DIV_ZERO, DONE.
- IDLE:
  - start_i & !annul_i: operands and op are latched.
  - op[1]=0 -> MUL_ON.
  - op[1]=1 & b_i==0 -> DIV_ZERO.
  - otherwise -> DIV_ON with counter=0.
  - start_i & annul_i: ignored, stay IDLE.
- Start cycle = cycle 0.
- MUL_ON:
  - Product formed in MUL_CYCLES cycles, then -> DONE.
  - MULT: signed 32x32->64. MULTU: unsigned.
- DIV_ON:
  - Restoring radix-2 division on magnitudes; exactly WIDTH iterations (cycles 1..32), one quotient bit per cycle, then -> DONE.
  - Signed (DIV): operand magnitudes taken at latch time. Quotient negated if the operand signs differ. Remainder takes the dividend's sign.
  - DIVU: no sign handling.
  - 0x80000000 / 0xFFFFFFFF yields q=0x80000000, r=0. No trap.
- DIV_ZERO: one cycle, result forced to {hi,lo}=0, -> DONE.
- DONE:
  - ready_o=1 for exactly this cycle; result_o updated on entry (registered).
  - -> IDLE next cycle.
  - A start_i arriving in DONE is ignored; the requester must re-present it in IDLE.
- Latency, start to ready: DIV/DIVU = WIDTH+1 (33); MUL = MUL_CYCLES+1 (2); divide-by-zero = 2.
- result_o:
  - Holds its last value until the next DONE.
  - Never changes on annul or in IDLE.
- busy_o, combinational:
  - =1 when (state==IDLE & start_i & !annul_i) or state in {MUL_ON, DIV_ON, DIV_ZERO}.
  - =0 in DONE (pipeline advances, consuming ready_o).
- annul_i in MUL_ON/DIV_ON/DIV_ZERO:
  - -> IDLE next edge; no ready pulse; result_o unchanged.
  - busy_o drops combinationally in that cycle.
- annul_i in DONE: ready_o is suppressed (gated combinationally); result_o keeps its new value, but no HI/LO write occurs.
- Operand inputs may change freely after the start cycle.

Optional Feature:
- Macro: MULDIV_DIVZERO_FLAG_EN.
- Defined:
  - Adds output divz_o (1 bit), reset 0.
  - divz_o=1 in the same cycle as ready_o for a DIV/DIVU with divisor 0; otherwise 0.
  - Clears on annul.
- Undefined: port absent; divide-by-zero still returns 0 with latency 2.

Test Plan:
- DIVU a=100, b=7, start at cycle 0 -> busy_o high cycles 0..32; ready_o at cycle 33; result_o={hi=2, lo=14}.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT a=0xFFFFFFFF, b=2 -> ready_o at cycle 2, result_o=0xFFFFFFFF_FFFFFFFE; MULTU same operands -> 0x00000001_FFFFFFFE.
- DIV a=5, b=0 -> ready_o at cycle 2, result_o=0; with MULDIV_DIVZERO_FLAG_EN, divz_o=1 with ready_o only.
- DIVU started, annul_i asserted at cycle 10 -> busy_o=0 that cycle, no ready_o, result_o keeps prior value; new MULTU 3x4 started next cycle -> result_o=12 at its cycle 2.
- rst_n asserted low at cycle 15 of a DIV -> all outputs 0 immediately (async); after release, start_i with DIVU 9/3 -> lo=3, hi=0 at cycle 33.
